vga_frame_sequencer: RTL
========================

Name: vga_frame_sequencer

Overview:
- Timing and fetch controller for the VGA picture path.
- Generates 640x480@60 Hz sync timing from the 25 MHz pixel clock.
- Sequences image-ROM reads for a 200x200 picture window and aligns returned ROM data with the delayed sync and blanking signals.
- Sits between the clock divider and the DAC/pins. Replaces the free-running horizontal/vertical counter pair with one start/stop-controlled sequencer.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch (H_TOTAL = 800)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch (V_TOTAL = 525)
- IMG_X, 200, window left column
- IMG_Y, 140, window top line
- IMG_W, 200, window width
- IMG_H, 200, window height
- ADDR_W, 16, ROM address width; must hold IMG_W*IMG_H-1
- DATA_W, 8, pixel width
- ROM_LAT, 2, ROM read latency in cycles (≥1)

Ports:
- clk_25M  in  1  pixel clock
- reset  in  1  asynchronous active-low reset
- run  in  1  level; 1 = generate frames, 0 = stop at end of frame
- rom_addr  out  ADDR_W  image ROM address
- rom_en  out  1  ROM read strobe, high only for window pixels
- rom_data  in  DATA_W  ROM output, valid ROM_LAT cycles after rom_addr/rom_en
- rgb  out  DATA_W  pixel to DAC
- hsync  out  1  active-low
- vsync  out  1  active-low
- video_on  out  1  high in the 640x480 active area
- frame_start  out  1  one-cycle pulse at the first pixel of each frame
- busy  out  1  high while not IDLE

Behaviour:
- Reset (async, reset=0): state IDLE; h=v=0; rom_addr=0; rom_en=0; rgb=0; hsync=vsync=1; video_on=0; frame_start=0; busy=0. All delay-pipe stages are cleared to the same inactive values.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN when run=1; counters start at (0,0) on the next cycle.
  - RUN→DRAIN when run=0.
  - DRAIN→RUN when run returns to 1 before the frame ends.
  - RUN/DRAIN→IDLE after the cycle with h=H_TOTAL-1 and v=V_TOTAL-1 in DRAIN.
  - A frame is never truncated except by reset.
- Counters (stage 0): h counts 0..H_TOTAL-1 and wraps to 0. v increments when h wraps, and wraps to 0 after V_TOTAL-1. Both are held at 0 in IDLE.
- Stage-0 decode:
  - act = h<H_ACTIVE && v<V_ACTIVE
  - hs = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), giving 656..751
  - vs = v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), giving 490..491
  - win = h in [IMG_X, IMG_X+IMG_W) && v in [IMG_Y, IMG_Y+IMG_H)
- Fetch (registered, stage 1):
  - rom_en = win.
  - rom_addr is a running counter: cleared when (h,v)=(0,0), incremented after each win pixel. This gives row-major addressing 0..IMG_W*IMG_H-1 (39999).
  - Outside the window, rom_addr holds its last value. No multiplier is used.
- Alignment:
  - act, hs, vs and win are delayed 1+ROM_LAT cycles.
  - hsync = ~hs_d, vsync = ~vs_d, video_on = act_d.
  - rgb = (act_d && win_d) ? rom_data : 0, registered.
  - All of hsync, vsync, video_on and rgb appear exactly 1+ROM_LAT cycles after their stage-0 counter value.
- frame_start: asserted 1+ROM_LAT cycles after stage-0 (0,0) in RUN/DRAIN, for exactly one cycle.
- busy: 1 in RUN and DRAIN.
- IDLE output rule:
  - Once the pipe drains, hsync=vsync=1 and rgb=0.
  - The final frame's delayed outputs still emerge for 1+ROM_LAT cycles after entering IDLE.
- Error handling: rom_data is ignored whenever win_d=0. Parameter sanity (IMG_X+IMG_W≤H_ACTIVE, IMG_Y+IMG_H≤V_ACTIVE) is checked at elaboration; violation is a fatal error.

Test Plan:
1. Reset release, run=1: hsync low for exactly 96 cycles starting 656+1+ROM_LAT = 659 cycles after the first counted pixel; line period 800; vsync low for 2 lines (1600 cycles) per 525-line frame (420000 cycles).
2. ROM model returning data=addr[7:0] with latency 2: rgb at screen (200,140) = 0x00, at (399,140) = 0xC7, at (200,141) = 0xC8 (addr 200), at (399,339) = addr 39999 → 0x3F; rgb=0 at (199,140) and (400,140); rom_en high exactly 40000 cycles per frame.
3. Drop run at line 100: frame completes to (799,524), busy falls, no further frame_start; re-raise run during DRAIN at line 300 → frames continue with no gap and busy stays 1.
4. Assert reset at h=300, v=200: on the same edge all outputs return to reset values; after release with run=1 a fresh frame starts at (0,0) with rom_addr=0.
5. Blanking: during h 640..799 or v 480..524, video_on=0 and rgb=0 regardless of rom_data=0xFF forced.
6. frame_start pulses exactly once per 420000 cycles, coincident with the first active pixel output at screen (0,0).

Source files
------------

// File: rtl/vga_frame_sequencer.sv
// Start/stop-controlled VGA timing sequencer with image-ROM fetch and output alignment.
// ROM_LAT counts clock edges from the edge that launches rom_addr to the edge at which rgb samples rom_data.
module vga_frame_sequencer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IMG_X    = 200,
  parameter int IMG_Y    = 140,
  parameter int IMG_W    = 200,
  parameter int IMG_H    = 200,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int ROM_LAT  = 2
) (
  input  logic              clk_25M,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              video_on,
  output logic              frame_start,
  output logic              busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] WX_BEG = HW'(IMG_X);
  localparam logic [HW-1:0] WX_END = HW'(IMG_X + IMG_W);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] WY_BEG = VW'(IMG_Y);
  localparam logic [VW-1:0] WY_END = VW'(IMG_Y + IMG_H);

  if (IMG_X + IMG_W > H_ACTIVE || IMG_Y + IMG_H > V_ACTIVE) begin : g_bad_window
    $fatal(1, "vga_frame_sequencer: image window exceeds the active area");
  end
  if (ROM_LAT < 1 || ADDR_W > 30 || IMG_W * IMG_H > (1 << ADDR_W)) begin : g_bad_rom
    $fatal(1, "vga_frame_sequencer: ROM_LAT or ADDR_W out of range");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic win;
    logic fs;
  } flags_t;

  state_t              state;
  logic [HW-1:0]       h;
  logic [VW-1:0]       v;
  logic [ADDR_W-1:0]   next_addr;
  flags_t              pipe [1:ROM_LAT];
  flags_t              f0;
  logic                counting;
  logic                h_last;
  logic                frame_end;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    f0        = '0;
    counting  = (state != IDLE);
    h_last    = (h == H_LAST);
    frame_end = h_last && (v == V_LAST);
    if (counting) begin
      f0.act = (h < H_ACT) && (v < V_ACT);
      f0.hs  = (h >= HS_BEG) && (h < HS_END);
      f0.vs  = (v >= VS_BEG) && (v < VS_END);
      f0.win = (h >= WX_BEG) && (h < WX_END) && (v >= WY_BEG) && (v < WY_END);
      f0.fs  = (h == '0) && (v == '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_25M or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      h           <= '0;
      v           <= '0;
      rom_addr    <= '0;
      next_addr   <= '0;
      rgb         <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
      // NOTE: the delay pipe is a handful of flops, not a RAM, so it is reset to drain to inactive.
      for (int i = 1; i <= ROM_LAT; i++) pipe[i] <= '0;
    end else begin
      case (state)
        IDLE:       if (run) state <= RUN;
        RUN, DRAIN: begin
          // Frames only stop on their last pixel; run is otherwise just a request.
          if (frame_end) state <= run ? RUN : IDLE;
          else           state <= run ? RUN : DRAIN;
        end
        default:    state <= IDLE;
      endcase

      if (counting) begin
        h <= h_last ? '0 : h + HW'(1);
        if (h_last) v <= (v == V_LAST) ? '0 : v + VW'(1);
      end

      // Row-major window address as a running count restarted at each frame origin.
      if (f0.fs) begin
        rom_addr  <= '0;
        next_addr <= f0.win ? ADDR_W'(1) : '0;
      end else if (f0.win) begin
        rom_addr  <= next_addr;
        next_addr <= next_addr + ADDR_W'(1);
      end

      pipe[1] <= f0;
      for (int i = 2; i <= ROM_LAT; i++) pipe[i] <= pipe[i-1];

      hsync       <= ~pipe[ROM_LAT].hs;
      vsync       <= ~pipe[ROM_LAT].vs;
      video_on    <= pipe[ROM_LAT].act;
      frame_start <= pipe[ROM_LAT].fs;
      rgb         <= (pipe[ROM_LAT].act && pipe[ROM_LAT].win) ? rom_data : '0;
    end
  end

  assign rom_en = pipe[1].win;
  assign busy   = (state != IDLE);

endmodule
